// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential word fetches to a synchronous memory and buffers
// returning instructions in a 2-entry FIFO, with redirect flush and backpressure handling.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 7,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_en_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0] out_pc_o
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic [DATA_W-1:0] head_instr_q, head_instr_d;
  logic [ADDR_W-1:0] tail_pc_q, tail_pc_d;
  logic [DATA_W-1:0] tail_instr_q, tail_instr_d;

  logic       out_fire;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign out_valid_o = (count_q != 2'd0);
  assign out_fire    = out_valid_o & out_ready_i;
  assign out_pc_o    = head_pc_q;
  assign out_instr_o = head_instr_q;
  assign imem_addr_o = fetch_pc_q;

  // Slots already claimed once this cycle's pop is accounted for; out_fire implies count >= 1.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, out_fire};
  assign issue     = fetch_en_i & ~redirect_valid_i & (occupancy < 3'd2);
  assign push      = inflight_q & ~redirect_valid_i;

  // Gated so that no fetch request escapes while reset is held.
  assign imem_en_o = issue & rst_ni;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_pc_d     = head_pc_q;
    head_instr_d  = head_instr_q;
    tail_pc_d     = tail_pc_q;
    tail_instr_d  = tail_instr_q;

    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
      count_d    = 2'd0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      end

      unique case ({push, out_fire})
        2'b01: begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          count_d      = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = inflight_pc_q;
            head_instr_d = imem_data_i;
          end else begin
            tail_pc_d    = inflight_pc_q;
            tail_instr_d = imem_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_pc_d    = inflight_pc_q;
            head_instr_d = imem_data_i;
          end else begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = inflight_pc_q;
            tail_instr_d = imem_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      head_pc_q     <= '0;
      head_instr_q  <= '0;
      tail_pc_q     <= '0;
      tail_instr_q  <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_pc_q     <= head_pc_d;
      head_instr_q  <= head_instr_d;
      tail_pc_q     <= tail_pc_d;
      tail_instr_q  <= tail_instr_d;
    end
  end

  count_in_range_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= 2'd2);

  no_push_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && count_q == 2'd2) |-> out_fire);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table covers fill, backpressure, redirect,
// wrap and fetch_en gaps; a hand-written sequence covers asynchronous reset mid-operation.
module tb_instr_fetch;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC(7'h00)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .fetch_en_i      (fetch_en),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .imem_en_o       (imem_en),
    .imem_addr_o     (imem_addr),
    .imem_data_i     (imem_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_instr_o     (out_instr),
    .out_pc_o        (out_pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word[a] = 0xA000_0000 + a.
  always @(posedge clk) begin
    if (imem_en) imem_data <= 32'hA000_0000 + 32'(imem_addr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          fe;
    logic          rd;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          en;
    logic [AW-1:0] addr;
    logic          ov;
    logic [AW-1:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fe, input logic rd, input logic [AW-1:0] rpc, input logic rdy,
                     input logic en, input logic [AW-1:0] addr, input logic ov,
                     input logic [AW-1:0] pc);
    vec_t v;
    v.fe = fe; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.en = en; v.addr = addr; v.ov = ov; v.pc = pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  initial begin
    // fe rd rpc rdy | en addr ov pc ; one entry per cycle, checked mid-cycle
    add(1, 0, 0, 1,   1, 7'h00, 0, 0);      // cold start
    add(1, 0, 0, 1,   1, 7'h01, 0, 0);
    add(1, 0, 0, 1,   1, 7'h02, 1, 7'h00);
    add(1, 0, 0, 1,   1, 7'h03, 1, 7'h01);
    add(1, 0, 0, 1,   1, 7'h04, 1, 7'h02);
    add(1, 0, 0, 0,   0, 7'h05, 1, 7'h03);  // backpressure, 5 cycles
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 7'h05, 1, 7'h03);
    add(1, 0, 0, 1,   1, 7'h05, 1, 7'h03);  // release
    add(1, 0, 0, 1,   1, 7'h06, 1, 7'h04);
    add(1, 0, 0, 0,   0, 7'h07, 1, 7'h05);  // buffer pcs 5,6
    add(1, 1, 7'h40, 0, 0, 7'h07, 1, 7'h05); // redirect to 0x40
    add(1, 0, 0, 1,   1, 7'h40, 0, 0);
    add(1, 0, 0, 1,   1, 7'h41, 0, 0);
    add(1, 0, 0, 1,   1, 7'h42, 1, 7'h40);
    add(1, 0, 0, 1,   1, 7'h43, 1, 7'h41);
    add(1, 1, 7'h7E, 1, 0, 7'h44, 1, 7'h42); // redirect while head fires
    add(1, 0, 0, 1,   1, 7'h7E, 0, 0);
    add(1, 0, 0, 1,   1, 7'h7F, 0, 0);
    add(1, 0, 0, 1,   1, 7'h00, 1, 7'h7E);
    add(1, 0, 0, 1,   1, 7'h01, 1, 7'h7F);
    add(1, 0, 0, 1,   1, 7'h02, 1, 7'h00);
    add(1, 0, 0, 1,   1, 7'h03, 1, 7'h01);
    add(0, 0, 0, 1,   0, 7'h04, 1, 7'h02);  // fetch_en low for 3 cycles
    add(0, 0, 0, 1,   0, 7'h04, 1, 7'h03);
    add(0, 0, 0, 1,   0, 7'h04, 0, 0);
    add(1, 0, 0, 1,   1, 7'h04, 0, 0);
    add(1, 0, 0, 1,   1, 7'h05, 0, 0);
    add(1, 0, 0, 1,   1, 7'h06, 1, 7'h04);
    add(1, 0, 0, 1,   1, 7'h07, 1, 7'h05);

    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #2;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_imem_en",   32'(imem_en),   0);
    chk("reset_imem_addr", 32'(imem_addr), 0);
    chk("reset_out_pc",    32'(out_pc),    0);
    chk("reset_out_instr", out_instr,      0);

    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      fetch_en       = vecs[i].fe;
      redirect_valid = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_imem_en", i),   32'(imem_en),   32'(vecs[i].en));
      chk($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_out_pc", i),    32'(out_pc), 32'(vecs[i].pc));
        chk($sformatf("v%0d_out_instr", i), out_instr,   word_of(vecs[i].pc));
      end
    end

    // Fill the FIFO to 2 entries, then assert reset between clock edges.
    @(negedge clk);
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b0;
    @(negedge clk);
    #1;
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_imem_en",   32'(imem_en),   0);
    chk("full_out_pc",    32'(out_pc),    32'h06);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_imem_en",   32'(imem_en),   0);
    chk("async_rst_imem_addr", 32'(imem_addr), 0);
    chk("async_rst_out_pc",    32'(out_pc),    0);
    chk("async_rst_out_instr", out_instr,      0);
    @(negedge clk);
    chk("rst_held_out_valid", 32'(out_valid), 0);
    chk("rst_held_imem_en",   32'(imem_en),   0);
    #1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    chk("post_rst_imem_en",   32'(imem_en),   1);
    chk("post_rst_imem_addr", 32'(imem_addr), 0);
    @(negedge clk);
    #1;
    chk("post_rst_addr1",  32'(imem_addr), 1);
    chk("post_rst_empty",  32'(out_valid), 0);
    @(negedge clk);
    #1;
    chk("post_rst_valid",  32'(out_valid), 1);
    chk("post_rst_pc",     32'(out_pc),    0);
    chk("post_rst_instr",  out_instr,      32'hA000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
